// File: rtl/vx_smem_serial.sv
// vx_smem_serial: banked shared memory that replays a multi-lane request until every lane has been served,
// one lane per bank per cycle, with same-address read broadcast.
module vx_smem_serial #(
    parameter NUM_REQS       = 4,
    parameter NUM_BANKS      = 4,
    parameter WORD_SIZE      = 4,
    parameter LINES_PER_BANK = 256,
    parameter TAG_WIDTH      = 10,
    parameter BANK_BITS      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    parameter ADDR_WIDTH     = $clog2(NUM_BANKS * LINES_PER_BANK)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic                              req_rw,
    input  logic [NUM_REQS-1:0]               req_tmask,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0]   req_data,
    input  logic [TAG_WIDTH-1:0]              req_tag,
    output logic                              req_ready,
    output logic                              rsp_valid,
    output logic [NUM_REQS-1:0]               rsp_tmask,
    output logic [NUM_REQS*8*WORD_SIZE-1:0]   rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready,
    output logic [31:0]                       perf_conflicts
);
    localparam DW    = 8 * WORD_SIZE;
    localparam ROW_W = ADDR_WIDTH - BANK_BITS;
    localparam BW    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam LW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RSP} state_t;
    state_t state, state_n;

    logic                          req_fire, rw_q, first_q;
    logic [NUM_REQS-1:0]           tmask_q, pend_q, served, served_q;
    logic [NUM_REQS*ADDR_WIDTH-1:0] addr_q;
    logic [NUM_REQS*WORD_SIZE-1:0] byteen_q;
    logic [NUM_REQS*DW-1:0]        data_q, rdata_q;
    logic [TAG_WIDTH-1:0]          tag_q;
    logic [31:0]                   conflicts_q;
    logic [ADDR_WIDTH-1:0]         lane_addr [NUM_REQS];
    logic [BW-1:0]                 lane_bank [NUM_REQS];
    logic [NUM_BANKS-1:0]          bank_en;
    logic [LW-1:0]                 bank_lane [NUM_BANKS];
    logic [DW-1:0]                 bank_dout [NUM_BANKS];

    assign req_fire = req_valid && req_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            lane_addr[i] = addr_q[i*ADDR_WIDTH +: ADDR_WIDTH];
            lane_bank[i] = (NUM_BANKS > 1) ? lane_addr[i][BW-1:0] : '0;
        end
    end

    // Descending scan leaves the lowest pending lane as each bank's winner.
    always_comb begin
        bank_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_lane[b] = '0;
            for (int i = NUM_REQS - 1; i >= 0; i--)
                if (pend_q[i] && lane_bank[i] == BW'(b)) begin
                    bank_en[b]   = state == ACCESS;
                    bank_lane[b] = LW'(i);
                end
        end
        served = '0;
        for (int i = 0; i < NUM_REQS; i++)
            served[i] = pend_q[i] && bank_en[lane_bank[i]] && (bank_lane[lane_bank[i]] == LW'(i) ||
                        (!rw_q && lane_addr[i] == lane_addr[bank_lane[lane_bank[i]]]));
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DW-1:0]        mem [LINES_PER_BANK];
        logic [DW-1:0]        dout, wd;
        logic [WORD_SIZE-1:0] be;
        logic [ROW_W-1:0]     row;
        assign row = lane_addr[bank_lane[g]][ADDR_WIDTH-1:BANK_BITS];
        assign be  = byteen_q[bank_lane[g]*WORD_SIZE +: WORD_SIZE];
        assign wd  = data_q[bank_lane[g]*DW +: DW];
        assign bank_dout[g] = dout;
        always_ff @(posedge clk) begin
            if (bank_en[g] && rw_q)
                for (int k = 0; k < WORD_SIZE; k++)
                    if (be[k]) mem[row][8*k +: 8] <= wd[8*k +: 8];
            if (bank_en[g] && !rw_q) dout <= mem[row];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = (req_fire && |req_tmask) ? ACCESS : IDLE;
            ACCESS: state_n = |(pend_q & ~served) ? ACCESS : (rw_q ? IDLE : WAIT);
            WAIT:   state_n = RSP;
            RSP:    state_n = rsp_ready ? IDLE : RSP;
        endcase
    end

    always_comb begin
        req_ready      = state == IDLE;
        rsp_valid      = state == RSP;
        rsp_tmask      = rsp_valid ? tmask_q : '0;
        rsp_tag        = rsp_valid ? tag_q : '0;
        rsp_data       = rdata_q;
        perf_conflicts = conflicts_q;
    end

    // Bank RAM output lags the access by one cycle, so lanes served last cycle are captured now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            tmask_q     <= '0;
            pend_q      <= '0;
            served_q    <= '0;
            addr_q      <= '0;
            byteen_q    <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            tag_q       <= '0;
            conflicts_q <= '0;
        end else begin
            served_q <= rw_q ? '0 : served;
            if (req_fire) begin
                rw_q     <= req_rw;
                tmask_q  <= req_tmask;
                pend_q   <= req_tmask;
                addr_q   <= req_addr;
                byteen_q <= req_byteen;
                data_q   <= req_data;
                tag_q    <= req_tag;
                first_q  <= 1'b1;
            end else begin
                pend_q <= pend_q & ~served;
            end
            if (state == ACCESS) begin
                first_q <= 1'b0;
                if (!first_q) conflicts_q <= conflicts_q + 32'd1;
            end
            for (int i = 0; i < NUM_REQS; i++)
                if (served_q[i]) rdata_q[i*DW +: DW] <= bank_dout[lane_bank[i]];
        end
    end
endmodule

// File: tb/tb_vx_smem_serial.sv
// tb_vx_smem_serial: table of read/write requests against a behavioural memory model,
// with a response scoreboard and hand-written zero-mask, stall and reset sequences.
module tb_vx_smem_serial;
    logic         clk = 1'b0, reset = 1'b0;
    logic         req_valid = 1'b0, req_rw = 1'b0, rsp_ready = 1'b1;
    logic [3:0]   req_tmask = '0;
    logic [39:0]  req_addr = '0;
    logic [15:0]  req_byteen = '0;
    logic [127:0] req_data = '0;
    logic [9:0]   req_tag = '0;
    logic         req_ready, rsp_valid;
    logic [3:0]   rsp_tmask;
    logic [127:0] rsp_data;
    logic [9:0]   rsp_tag;
    logic [31:0]  perf_conflicts;

    typedef struct {
        logic             rw;
        logic [3:0]       tmask;
        logic [3:0][9:0]  addr;
        logic [3:0][3:0]  be;
        logic [3:0][31:0] data;
        logic [9:0]       tag;
        int               lat;
        int               dconf;
        int               hold;
    } vec_t;

    typedef struct {
        logic [3:0]       tmask;
        logic [9:0]       tag;
        logic [3:0][31:0] data;
    } exp_t;

    vec_t        vecs [10];
    exp_t        sb [$];
    logic [31:0] mm [1024];
    logic [31:0] exp_conf = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    vx_smem_serial dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw), .req_tmask(req_tmask),
        .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_ready(rsp_ready), .perf_conflicts(perf_conflicts)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_rsp(input string name, input exp_t e);
        check({name, "_tmask"}, 64'(rsp_tmask), 64'(e.tmask));
        check({name, "_tag"}, 64'(rsp_tag), 64'(e.tag));
        for (int i = 0; i < 4; i++)
            if (e.tmask[i]) check($sformatf("%s_data%0d", name, i), 64'(rsp_data[i*32 +: 32]), 64'(e.data[i]));
    endtask

    task automatic run(input string name, input vec_t v);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check({name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_rw = v.rw; req_tmask = v.tmask; req_addr = v.addr;
        req_byteen = v.be; req_data = v.data; req_tag = v.tag; rsp_ready = v.hold == 0;
        if (v.rw) begin
            for (int i = 0; i < 4; i++)
                if (v.tmask[i])
                    for (int k = 0; k < 4; k++)
                        if (v.be[i][k]) mm[v.addr[i]][8*k +: 8] = v.data[i][8*k +: 8];
        end else begin
            e.tmask = v.tmask; e.tag = v.tag;
            for (int i = 0; i < 4; i++) e.data[i] = mm[v.addr[i]];
            sb.push_back(e);
        end
        exp_conf += 32'(v.dconf);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(v.rw ? req_ready : rsp_valid) && cyc < 50);
        check({name, "_latency"}, 64'(cyc), 64'(v.lat));
        check({name, "_conflicts"}, 64'(perf_conflicts), 64'(exp_conf));
        if (!v.rw) begin
            if (sb.size() == 0) check({name, "_sb_empty"}, 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                cmp_rsp(name, e);
            end
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                check({name, "_hold_valid"}, 64'(rsp_valid), 64'd1);
                check({name, "_hold_ready"}, 64'(req_ready), 64'd0);
                cmp_rsp({name, "_hold"}, e);
            end
            if (v.hold > 0) begin
                rsp_ready = 1'b1;
                @(negedge clk);
                check({name, "_released"}, 64'(rsp_valid), 64'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 1024; a++) mm[a] = '0;
        vecs[0] = '{1'b1, 4'hF, {10'd3, 10'd2, 10'd1, 10'd0}, {4{4'hF}},
                    {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 10'd1, 2, 0, 0};
        vecs[1] = '{1'b0, 4'hF, {10'd3, 10'd2, 10'd1, 10'd0}, '0, '0, 10'd2, 3, 0, 0};
        vecs[2] = '{1'b1, 4'hF, {10'd5, 10'd12, 10'd8, 10'd4}, {4{4'hF}},
                    {32'h55, 32'hBC, 32'hB8, 32'hB4}, 10'd3, 4, 2, 0};
        vecs[3] = '{1'b0, 4'hF, {10'd12, 10'd8, 10'd4, 10'd0}, '0, '0, 10'd4, 6, 3, 0};
        vecs[4] = '{1'b0, 4'hF, {4{10'd5}}, '0, '0, 10'd5, 3, 0, 0};
        vecs[5] = '{1'b1, 4'b0101, {10'd0, 10'd7, 10'd0, 10'd7}, {4{4'hF}},
                    {32'h0, 32'h22, 32'h0, 32'h11}, 10'd6, 3, 1, 0};
        vecs[6] = '{1'b0, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd7}, '0, '0, 10'h155, 3, 0, 5};
        vecs[7] = '{1'b1, 4'b0010, {10'd0, 10'd0, 10'd1, 10'd0}, {4'h0, 4'h0, 4'h3, 4'h0},
                    {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0}, 10'd7, 2, 0, 0};
        vecs[8] = '{1'b0, 4'b1010, {10'd2, 10'd0, 10'd1, 10'd0}, '0, '0, 10'h2AA, 3, 0, 0};
        vecs[9] = '{1'b0, 4'hF, {10'd0, 10'd5, 10'd1, 10'd5}, '0, '0, 10'h3FF, 4, 1, 0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_tmask", 64'(rsp_tmask), 64'd0);
        check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
        check("reset_conflicts", 64'(perf_conflicts), 64'd0);

        for (int n = 0; n < 10; n++) run($sformatf("vec%0d", n), vecs[n]);

        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_tmask = '0; req_addr = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("zero_mask_rsp", 64'(rsp_valid), 64'd0);
            check("zero_mask_ready", 64'(req_ready), 64'd1);
        end

        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_tmask = 4'hF;
        req_addr = {10'd12, 10'd8, 10'd4, 10'd0};
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_conf = '0;
        @(negedge clk);
        check("abort_conf_in_reset", 64'(perf_conflicts), 64'(exp_conf));
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
            check("abort_ready", 64'(req_ready), 64'd1);
        end
        check("abort_conflicts", 64'(perf_conflicts), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
